// File: rtl/display_pkg.sv
// Shared types and constants for the display channel sequencer.
//   state_t      : sequencer mode (off, single channel, invalid switches, auto-scan)
//   DP_VOLT      : decimal point after the leading digit (X.XXX)
//   DP_NONE      : no decimal points
//   err_pattern  : all-4'hE fill used for the invalid-switch display value
package display_pkg;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_SINGLE = 2'd1,
    S_ERR    = 2'd2,
    S_SCAN   = 2'd3
  } state_t;

  localparam logic [3:0] DP_VOLT = 4'b1000;
  localparam logic [3:0] DP_NONE = 4'b0000;

  localparam int MAX_DATA_W = 64;

  // Nibbles below data_w are 4'hE, anything above is zero; callers truncate.
  function automatic logic [MAX_DATA_W-1:0] err_pattern(input int data_w);
    logic [MAX_DATA_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < MAX_DATA_W / 4; i++) begin
      if (i < data_w / 4) pat[i*4 +: 4] = 4'hE;
    end
    return pat;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus stability timer for a vector of raw switches.
// The debounced vector only takes a new value after the synchronised vector
// has held still for CYCLES consecutive cycles.
//   clk    : system clock
//   reset  : synchronous active-high reset
//   sw_raw : asynchronous switch inputs
//   sw_db  : debounced, registered switch vector
module switch_debouncer #(
  parameter int WIDTH  = 12,
  parameter int CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db
);

  localparam int               CNT_W    = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [CNT_W-1:0] stable_cnt;

  // sync_q1 is what sync_q2 becomes on this edge, so comparing the two
  // restarts the timer on the same edge the synchronised vector changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1    <= '0;
      sync_q2    <= '0;
      stable_cnt <= '0;
      sw_db      <= '0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
      if (sync_q1 != sync_q2) begin
        stable_cnt <= CNT_LOAD;
      end else if (stable_cnt != '0) begin
        stable_cnt <= stable_cnt - 1'b1;
      end else begin
        sw_db <= sync_q2;
      end
    end
  end

endmodule

// File: rtl/display_channel_sequencer.sv
// Picks which measurement channel feeds the seven-segment path and LEDs,
// either from one-hot switches or by auto-scanning enabled channels, and
// registers the value together with its display format.
//   clk         : system clock
//   reset       : synchronous active-high reset
//   sw_mode     : raw one-hot channel select switches
//   sw_dec      : raw force-decimal switch
//   sw_auto     : raw auto-scan enable
//   sw_hold     : raw hold/freeze switch
//   ch_data     : packed channel values, channel i at [i*DATA_W +: DATA_W]
//   value_out   : registered selected value
//   use_decimal : 1 = downstream shows BCD, 0 = hex
//   dp_mask     : decimal point enables for digits 4..1
//   ch_idx      : index of the displayed channel
//   err         : invalid switch combination active
//   update      : one-cycle pulse when the output bundle changes
//
// state    | meaning
// S_OFF    | no channel selected, display blank value 0
// S_SINGLE | exactly one mode switch set, show that channel
// S_ERR    | several mode switches set, show error code
// S_SCAN   | auto-scan rotates through SCAN_MASK channels
module display_channel_sequencer
  import display_pkg::*;
#(
  parameter int                 NUM_CH          = 9,
  parameter int                 DATA_W          = 16,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 DWELL_CYCLES    = 100_000_000,
  parameter logic [NUM_CH-1:0]  DEC_MASK        = 9'b010010010,
  parameter logic [NUM_CH-1:0]  VOLT_MASK       = 9'b010010010,
  parameter logic [NUM_CH-1:0]  SCAN_MASK       = '1,
  parameter logic [DATA_W-1:0]  ERR_CODE        = DATA_W'(err_pattern(DATA_W))
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          sw_mode,
  input  logic                       sw_dec,
  input  logic                       sw_auto,
  input  logic                       sw_hold,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic [DATA_W-1:0]          value_out,
  output logic                       use_decimal,
  output logic [3:0]                 dp_mask,
  output logic [$clog2(NUM_CH)-1:0]  ch_idx,
  output logic                       err,
  output logic                       update
);

  localparam int                   IDX_W      = $clog2(NUM_CH);
  localparam int                   SW_W       = NUM_CH + 3;
  localparam int                   DWELL_W    = $clog2(DWELL_CYCLES);
  localparam logic [DWELL_W-1:0]   DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  logic [SW_W-1:0]   sw_db;
  logic [NUM_CH-1:0] db_mode;
  logic              db_dec;
  logic              db_auto;
  logic              db_hold;

  switch_debouncer #(
    .WIDTH  (SW_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .sw_raw ({sw_hold, sw_auto, sw_dec, sw_mode}),
    .sw_db  (sw_db)
  );

  assign db_mode = sw_db[NUM_CH-1:0];
  assign db_dec  = sw_db[NUM_CH];
  assign db_auto = sw_db[NUM_CH+1];
  assign db_hold = sw_db[NUM_CH+2];

  state_t             state;
  state_t             nxt_state;
  logic [IDX_W-1:0]   scan_idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [IDX_W-1:0]   single_idx;
  logic [IDX_W-1:0]   scan_first;
  logic [IDX_W-1:0]   scan_succ;
  logic [IDX_W-1:0]   disp_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid;
  logic               entering;
  logic               dwell_tc;
  int                 mode_ones;
  int                 succ_pos;

  logic [DATA_W-1:0]  nxt_value;
  logic               nxt_dec;
  logic [3:0]         nxt_dp;
  logic [IDX_W-1:0]   nxt_idx;
  logic               nxt_err;

  always_comb begin
    mode_ones  = 0;
    single_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (db_mode[i]) begin
        mode_ones  = mode_ones + 1;
        single_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    if (db_auto)             nxt_state = S_SCAN;
    else if (mode_ones == 0) nxt_state = S_OFF;
    else if (mode_ones == 1) nxt_state = S_SINGLE;
    else                     nxt_state = S_ERR;
  end

  // Walking down means the lowest set bit is the last one written.
  always_comb begin
    scan_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (SCAN_MASK[i]) scan_first = IDX_W'(i);
    end
  end

  // Nearest enabled channel after scan_idx, wrapping; a lone enabled
  // channel is found at offset NUM_CH, i.e. itself.
  always_comb begin
    scan_succ = scan_idx;
    succ_pos  = 0;
    for (int off = NUM_CH; off >= 1; off--) begin
      succ_pos = int'(scan_idx) + off;
      if (succ_pos >= NUM_CH) succ_pos = succ_pos - NUM_CH;
      if (SCAN_MASK[IDX_W'(succ_pos)]) scan_succ = IDX_W'(succ_pos);
    end
  end

  assign entering = (nxt_state == S_SCAN) && (state != S_SCAN);
  assign dwell_tc = (dwell_cnt == '0);

  // Scan index as it will stand after this edge, so the output register
  // shows the new channel on the same edge the index moves.
  always_comb begin
    if (entering)                                  disp_idx = scan_first;
    else if (state == S_SCAN && !db_hold && dwell_tc) disp_idx = scan_succ;
    else                                           disp_idx = scan_idx;
  end

  always_comb begin
    nxt_value = '0;
    nxt_dec   = 1'b0;
    nxt_dp    = DP_NONE;
    nxt_idx   = '0;
    nxt_err   = 1'b0;
    sel_idx   = '0;
    sel_valid = 1'b0;
    case (nxt_state)
      S_SINGLE: begin
        sel_idx   = single_idx;
        sel_valid = 1'b1;
      end
      S_SCAN: begin
        sel_idx   = disp_idx;
        sel_valid = (SCAN_MASK != '0);
      end
      S_ERR: begin
        nxt_value = ERR_CODE;
        nxt_idx   = ch_idx;
        nxt_err   = 1'b1;
      end
      default: ;
    endcase
    if (sel_valid) begin
      nxt_value = ch_data[sel_idx*DATA_W +: DATA_W];
      nxt_idx   = sel_idx;
      nxt_dec   = db_dec | DEC_MASK[sel_idx];
      nxt_dp    = VOLT_MASK[sel_idx] ? DP_VOLT : DP_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_OFF;
      scan_idx    <= '0;
      dwell_cnt   <= '0;
      value_out   <= '0;
      use_decimal <= 1'b0;
      dp_mask     <= DP_NONE;
      ch_idx      <= '0;
      err         <= 1'b0;
      update      <= 1'b0;
    end else begin
      state <= nxt_state;

      if (entering) begin
        scan_idx  <= scan_first;
        dwell_cnt <= DWELL_LOAD;
      end else if (state == S_SCAN && !db_hold) begin
        if (dwell_tc) begin
          scan_idx  <= scan_succ;
          dwell_cnt <= DWELL_LOAD;
        end else begin
          dwell_cnt <= dwell_cnt - 1'b1;
        end
      end

      if (db_hold) begin
        update <= 1'b0;
      end else begin
        update      <= {nxt_value, nxt_dec, nxt_dp, nxt_idx, nxt_err} !=
                       {value_out, use_decimal, dp_mask, ch_idx, err};
        value_out   <= nxt_value;
        use_decimal <= nxt_dec;
        dp_mask     <= nxt_dp;
        ch_idx      <= nxt_idx;
        err         <= nxt_err;
      end
    end
  end

endmodule

// File: tb/tb_display_channel_sequencer.sv
// Bench for display_channel_sequencer: directed scenarios followed by random
// switch/data activity, all compared against a behavioural model.
module tb_display_channel_sequencer;

  localparam int NUM_CH = 9;
  localparam int DATA_W = 16;
  localparam int DEB    = 4;
  localparam int DWELL  = 8;
  localparam int WIN    = DEB + 1;
  localparam int NSW    = NUM_CH + 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_CH-1:0]        sw_mode = '0;
  logic                     sw_dec = 1'b0;
  logic                     sw_auto = 1'b0;
  logic                     sw_hold = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [DATA_W-1:0]        value_out;
  logic                     use_decimal;
  logic [3:0]               dp_mask;
  logic [3:0]               ch_idx;
  logic                     err;
  logic                     update;

  logic [8:0] dec_m  = 9'b010010010;
  logic [8:0] volt_m = 9'b010010010;
  logic [8:0] scan_m = 9'b000010010;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;
  bit upd_seen = 0;

  always #5 clk = ~clk;

  display_channel_sequencer #(
    .NUM_CH          (NUM_CH),
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (DEB),
    .DWELL_CYCLES    (DWELL),
    .DEC_MASK        (9'b010010010),
    .VOLT_MASK       (9'b010010010),
    .SCAN_MASK       (9'b000010010)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_mode     (sw_mode),
    .sw_dec      (sw_dec),
    .sw_auto     (sw_auto),
    .sw_hold     (sw_hold),
    .ch_data     (ch_data),
    .value_out   (value_out),
    .use_decimal (use_decimal),
    .dp_mask     (dp_mask),
    .ch_idx      (ch_idx),
    .err         (err),
    .update      (update)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] chan(input int i);
    return ch_data[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_chan(input int i, input logic [DATA_W-1:0] v);
    ch_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (update === 1'b1) upd_seen = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // Reference model: a switch vector is accepted once the raw inputs have
  // been sampled equal on WIN consecutive edges; scanning walks a list of
  // enabled channels spending DWELL cycles on each.
  logic [NSW-1:0]    hist [WIN];
  logic [NSW-1:0]    m_db = '0;
  bit                m_in_scan = 0;
  int                m_pos = 0;
  int                m_age = 0;
  int                en_list [$];
  logic [DATA_W-1:0] e_val = '0;
  logic              e_dec = 0;
  logic [3:0]        e_dp = '0;
  logic [3:0]        e_idx = '0;
  logic              e_err = 0;
  logic              e_upd = 0;

  logic [NUM_CH-1:0] d_mode;
  logic              d_dec, d_auto, d_hold, show, stable;
  int                ones, k;
  logic [DATA_W-1:0] n_val;
  logic              n_dec, n_err;
  logic [3:0]        n_dp, n_idx;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) hist[i] = '0;
      m_db = '0; m_in_scan = 0; m_pos = 0; m_age = 0;
      e_val = '0; e_dec = 0; e_dp = '0; e_idx = '0; e_err = 0; e_upd = 0;
      en_list.delete();
      for (int i = 0; i < NUM_CH; i++) if (scan_m[i]) en_list.push_back(i);
    end else begin
      d_mode = m_db[NUM_CH-1:0];
      d_dec  = m_db[NUM_CH];
      d_auto = m_db[NUM_CH+1];
      d_hold = m_db[NUM_CH+2];
      ones = 0; k = 0;
      for (int i = 0; i < NUM_CH; i++) if (d_mode[i]) begin ones++; k = i; end
      n_val = '0; n_dec = 0; n_dp = 4'b0000; n_idx = '0; n_err = 0; show = 0;
      if (d_auto) begin
        if (!m_in_scan) begin
          m_pos = 0; m_age = 0;
        end else if (!d_hold) begin
          if (m_age == DWELL - 1) begin
            m_pos = (m_pos + 1) % en_list.size();
            m_age = 0;
          end else m_age++;
        end
        k = en_list[m_pos];
        show = 1;
      end else if (ones == 1) begin
        show = 1;
      end else if (ones > 1) begin
        n_val = 16'hEEEE; n_err = 1; n_idx = e_idx;
      end
      if (show) begin
        n_val = chan(k);
        n_idx = 4'(k);
        n_dec = d_dec | dec_m[k];
        n_dp  = volt_m[k] ? 4'b1000 : 4'b0000;
      end
      m_in_scan = d_auto;
      if (d_hold) e_upd = 0;
      else begin
        e_upd = {n_val, n_dec, n_dp, n_idx, n_err} != {e_val, e_dec, e_dp, e_idx, e_err};
        e_val = n_val; e_dec = n_dec; e_dp = n_dp; e_idx = n_idx; e_err = n_err;
      end
      stable = 1;
      for (int i = 1; i < WIN; i++) if (hist[i] != hist[0]) stable = 0;
      if (stable) m_db = hist[WIN-1];
      for (int i = 0; i < WIN - 1; i++) hist[i] = hist[i+1];
      hist[WIN-1] = {sw_hold, sw_auto, sw_dec, sw_mode};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("model_value", value_out, e_val);
      check_eq("model_dec", use_decimal, e_dec);
      check_eq("model_dp", dp_mask, e_dp);
      check_eq("model_idx", ch_idx, e_idx);
      check_eq("model_err", err, e_err);
      check_eq("model_update", update, e_upd);
    end
  end

  logic [DATA_W-1:0] d4, d4n;
  int a, b, dur;

  initial begin
    do_reset();
    chk_en = 1;
    check_eq("rst_value", value_out, 0);
    check_eq("rst_dec", use_decimal, 0);
    check_eq("rst_dp", dp_mask, 0);
    check_eq("rst_idx", ch_idx, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_update", update, 0);

    // single channel, debounce latency
    set_chan(1, 16'd3300);
    sw_mode = 9'h002;
    tick(6);
    check_eq("lat_early_value", value_out, 0);
    tick(1);
    check_eq("single_value", value_out, 16'd3300);
    check_eq("single_dec", use_decimal, 1);
    check_eq("single_dp", dp_mask, 4'b1000);
    check_eq("single_idx", ch_idx, 1);
    check_eq("single_update", update, 1);
    tick(1);
    check_eq("single_update_once", update, 0);

    // bouncing switch never accepted
    sw_mode = '0;
    do_reset();
    upd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      sw_mode = 9'h001; tick(2);
      sw_mode = 9'h000; tick(2);
    end
    check_eq("bounce_update", upd_seen, 0);
    check_eq("bounce_value", value_out, 0);
    set_chan(0, 16'h0ABC);
    sw_mode = 9'h001;
    tick(7);
    check_eq("ch0_value", value_out, 16'h0ABC);
    check_eq("ch0_dec", use_decimal, 0);
    check_eq("ch0_dp", dp_mask, 0);

    // invalid combination, then recovery
    sw_mode = 9'h011;
    tick(7);
    check_eq("err_value", value_out, 16'hEEEE);
    check_eq("err_flag", err, 1);
    check_eq("err_dec", use_decimal, 0);
    check_eq("err_dp", dp_mask, 0);
    check_eq("err_idx_hold", ch_idx, 0);
    d4 = 16'($urandom);
    set_chan(4, d4);
    sw_mode = 9'h010;
    tick(7);
    check_eq("clr_err", err, 0);
    check_eq("clr_value", value_out, d4);
    check_eq("clr_idx", ch_idx, 4);
    d4 = ~d4;
    set_chan(4, d4);
    tick(1);
    check_eq("live_value", value_out, d4);
    check_eq("live_update", update, 1);

    // auto-scan 1,4,1,4
    sw_auto = 1;
    tick(7);
    check_eq("scan_entry_idx", ch_idx, 1);
    check_eq("scan_entry_update", update, 1);
    for (int s = 0; s < 3; s++) begin
      tick(7);
      check_eq("scan_dwell_quiet", update, 0);
      tick(1);
      check_eq("scan_step_idx", ch_idx, (s % 2 == 0) ? 4 : 1);
      check_eq("scan_step_update", update, 1);
    end

    // hold freezes outputs and dwell
    sw_hold = 1;
    tick(6);
    upd_seen = 0;
    tick(1);
    for (int i = 0; i < 23; i++) begin
      set_chan(4, 16'($urandom));
      tick(1);
    end
    check_eq("hold_value", value_out, d4);
    check_eq("hold_idx", ch_idx, 4);
    d4n = ~d4;
    set_chan(4, d4n);
    sw_hold = 0;
    tick(6);
    check_eq("hold_no_update", upd_seen, 0);
    check_eq("hold_still_value", value_out, d4);
    tick(1);
    check_eq("release_value", value_out, d4n);
    check_eq("release_idx", ch_idx, 4);
    check_eq("release_update", update, 1);
    tick(1);
    check_eq("resume_step_idx", ch_idx, 1);

    // reset mid-scan
    tick(3);
    do_reset();
    check_eq("midrst_value", value_out, 0);
    check_eq("midrst_idx", ch_idx, 0);
    check_eq("midrst_dp", dp_mask, 0);
    check_eq("midrst_update", update, 0);
    tick(6);
    check_eq("midrst_debounce_value", value_out, 0);
    tick(1);
    check_eq("midrst_rescan_idx", ch_idx, 1);
    check_eq("midrst_rescan_value", value_out, 16'd3300);

    // random activity against the model
    for (int seg = 0; seg < 160; seg++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      case ($urandom_range(0, 3))
        0: sw_mode = '0;
        1, 2: sw_mode = 9'd1 << $urandom_range(0, 8);
        default: begin
          a = $urandom_range(0, 8);
          b = (a + 1 + $urandom_range(0, 7)) % 9;
          sw_mode = (9'd1 << a) | (9'd1 << b);
        end
      endcase
      sw_auto = ($urandom_range(0, 3) == 0);
      sw_hold = ($urandom_range(0, 5) == 0);
      sw_dec  = 1'($urandom_range(0, 1));
      dur = $urandom_range(1, 14);
      for (int d = 0; d < dur; d++) begin
        if ($urandom_range(0, 2) == 0) set_chan($urandom_range(0, 8), 16'($urandom));
        tick(1);
      end
    end

    tick(2);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/display_channel_sequencer.md
Name: display_channel_sequencer

Overview:
- Parametrised successor to the switch-driven display selector. Selects one of NUM_CH measurement channels for the seven-segment path and LEDs.
- Adds: synchronised and debounced switch inputs, an auto-scan mode that rotates through enabled channels, a hold/freeze control, per-channel format masks, and registered outputs with an update strobe.
- Sits between the ADC measurement blocks and the bin_to_bcd / mux / seven_segment_display_subsystem chain.

Parameters:
- NUM_CH, 9, number of measurement channels (2..16).
- DATA_W, 16, channel value width (multiple of 4).
- DEBOUNCE_CYCLES, 1_000_000, cycles a switch vector must be stable before it is accepted (≥2).
- DWELL_CYCLES, 100_000_000, cycles each channel is displayed during auto-scan (≥2).
- DEC_MASK, 9'b010010010, bit i=1: channel i defaults to decimal format.
- VOLT_MASK, 9'b010010010, bit i=1: channel i lights DP on digit 4 (X.XXX).
- SCAN_MASK, all ones, bit i=1: channel i is visited by auto-scan.
- ERR_CODE, all nibbles 4'hE, value shown on an invalid switch combination.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- sw_mode, in, NUM_CH, raw one-hot channel select switches (asynchronous).
- sw_dec, in, 1, raw force-decimal switch.
- sw_auto, in, 1, raw auto-scan enable switch.
- sw_hold, in, 1, raw hold/freeze switch.
- ch_data, in, NUM_CH*DATA_W, packed channel values; channel i is bits [i*DATA_W +: DATA_W].
- value_out, out, DATA_W, selected value, registered; also drives the LEDs.
- use_decimal, out, 1, 1=downstream shows BCD, 0=hex.
- dp_mask, out, 4, decimal-point enables for digits 4..1.
- ch_idx, out, $clog2(NUM_CH), index of the displayed channel.
- err, out, 1, invalid switch combination is active.
- update, out, 1, one-cycle pulse when value_out, ch_idx or format changes.

Behaviour:
- Reset: synchronous, active-high; one clock; all state cleared.
  - Outputs, synchroniser flops, debounced vector, counters and scan index all go to 0.
  - FSM goes to S_OFF.
  - Reset asserted mid-scan or mid-debounce aborts immediately; no pending update is issued.
- Input conditioning:
  - 2-flop synchroniser on {sw_hold, sw_auto, sw_dec, sw_mode}.
  - Stability counter restarts whenever the synchronised vector differs from its previous-cycle value.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced vector loads the synchronised vector.
  - Latency from a raw change held stable to the debounced change: 2+DEBOUNCE_CYCLES cycles.
- FSM, evaluated each cycle on the debounced switches; sw_auto has priority:
  - S_SCAN if auto=1.
  - Otherwise S_OFF if popcount(mode)=0.
  - Otherwise S_SINGLE if popcount(mode)=1.
  - Otherwise S_ERR.
- S_OFF: next value=0, hex, dp=0, ch_idx=0, err=0.
- S_SINGLE:
  - Next value=ch_data[k], where k is the set bit; ch_idx=k.
  - use_decimal=sw_dec|DEC_MASK[k].
  - dp_mask=VOLT_MASK[k] ? 4'b1000 : 4'b0000.
- S_ERR: next value=ERR_CODE, hex, dp=0, err=1, ch_idx holds its last value.
- S_SCAN:
  - On entry, scan index = lowest enabled SCAN_MASK bit, and the dwell counter is cleared.
  - The dwell counter counts to DWELL_CYCLES-1. On the terminal count it advances to the next enabled index, wrapping from highest to lowest, and clears.
  - If only one bit is enabled, the index stays fixed.
  - If SCAN_MASK=0, behaves as S_OFF.
  - Format and DP follow the per-channel rules, as in S_SINGLE.
  - Displayed value tracks live ch_data of the current index.
- Output register:
  - value_out/use_decimal/dp_mask/ch_idx/err load the next values one cycle after the FSM/selection resolves.
  - Live ch_data changes are reflected with 1-cycle latency.
- Hold (debounced sw_hold=1):
  - All output registers keep their values, and no update pulses occur.
  - Dwell counter and scan index pause.
  - FSM state still tracks the switches.
  - On release, outputs reload on the next cycle, and update pulses if any output differs.
- update: registered compare of the new versus current output bundle; high for exactly one cycle per change; never high during hold or reset.
- Simultaneous events: a switch change in the same cycle as a dwell terminal count lets the FSM transition win, and the scan index is reinitialised.

Decomposition:
- Package display_pkg:
  - state enum {S_OFF, S_SINGLE, S_ERR, S_SCAN}.
  - DP_VOLT = 4'b1000 and DP_NONE = 4'b0000.
  - Function err_pattern(DATA_W) returning all-4'hE.
- Sub-module switch_debouncer:
  - Parameters WIDTH and CYCLES.
  - Contains the synchroniser and stability counter.
  - Instantiated once for the NUM_CH+3 switch bits.

Test Plan (NUM_CH=9, DEBOUNCE_CYCLES=4, DWELL_CYCLES=8, default masks):
- Raw sw_mode=9'h002 held, ch_data[1]=16'd3300 → after 2+4 cycles plus 1, value_out=3300, use_decimal=1, dp_mask=1000, ch_idx=1, update pulses once.
- sw_mode toggles 9'h001↔0 every 2 cycles for 20 cycles → value_out stays 0 and update never asserts; then hold 9'h001 with ch_data[0]=16'h0ABC → value_out=0ABC, hex, dp=0.
- Debounced sw_mode=9'h011 → value_out=EEEE, err=1, use_decimal=0, dp=0; clear to 9'h010 → err=0, value_out=ch_data[4].
- sw_auto=1, SCAN_MASK=9'b000010010 → ch_idx sequence 1,4,1,4…, with 8 cycles per step and an update pulse each step.
- In scan at ch_idx=4, assert sw_hold for 30 cycles while ch_data[4] changes → outputs frozen, no update; release → resumes at index 4 with the dwell counter from its paused value.
- Reset asserted for 1 cycle mid-scan → next cycle all outputs are 0, state is S_OFF, and the debounce process restarts.
